// File: rtl/riscv_mc_controller_if.sv
// Unified instruction/data memory port of the multi-cycle RV32I core.
// The controller masters the req/ready handshake and the address select.
interface riscv_mc_controller_if;
  logic MemReq;
  logic MemWrite;
  logic AdrSrc;
  logic MemReady;

  modport master (output MemReq, output MemWrite, output AdrSrc, input MemReady);
  modport slave  (input MemReq, input MemWrite, input AdrSrc, output MemReady);
endinterface

// File: rtl/riscv_mc_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute over one shared
// memory port and drives every datapath mux/enable; halts on illegal ops or memory timeouts.
module riscv_mc_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int ALUCTRL_W   = 4,
  parameter int IMMSRC_W    = 3
) (
  input  logic                     Clk,
  input  logic                     Rst,
  riscv_mc_controller_if.master    mem,
  input  logic [6:0]               op,
  input  logic [2:0]               func3,
  input  logic [6:0]               func7,
  input  logic                     Zero,
  output logic                     IRWrite,
  output logic                     PCWrite,
  output logic                     RegWrite,
  output logic [1:0]               ResultSrc,
  output logic [1:0]               ALUSrcA,
  output logic [1:0]               ALUSrcB,
  output logic [ALUCTRL_W-1:0]     ALUControl,
  output logic [IMMSRC_W-1:0]      ImmSrc,
  output logic                     InstrDone,
  output logic                     Halted
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR2, S_LUI, S_AUIPC, S_HALT
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_AND  = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(3);
  localparam logic [ALUCTRL_W-1:0] ALU_XOR  = ALUCTRL_W'(4);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(5);
  localparam logic [ALUCTRL_W-1:0] ALU_SLTU = ALUCTRL_W'(6);
  localparam logic [ALUCTRL_W-1:0] ALU_SLL  = ALUCTRL_W'(7);
  localparam logic [ALUCTRL_W-1:0] ALU_SRL  = ALUCTRL_W'(8);
  localparam logic [ALUCTRL_W-1:0] ALU_SRA  = ALUCTRL_W'(9);

  localparam logic [IMMSRC_W-1:0] IMM_I = IMMSRC_W'(0);
  localparam logic [IMMSRC_W-1:0] IMM_S = IMMSRC_W'(1);
  localparam logic [IMMSRC_W-1:0] IMM_B = IMMSRC_W'(2);
  localparam logic [IMMSRC_W-1:0] IMM_U = IMMSRC_W'(4);

  state_t     state_reg, state_next;
  logic [7:0] wait_cnt_reg, wait_next;
  logic       halted_reg;
  logic [8:0] wait_inc;
  logic       timeout_hit;
  logic       mem_req, mem_write, adr_src;
  logic [ALUCTRL_W-1:0] alu_op_dec, alu_br;
  logic       br_taken, br_illegal;
  logic       unused_func7;

  assign unused_func7 = ^{func7[6], func7[4:0]};
  assign wait_inc     = {1'b0, wait_cnt_reg} + 9'd1;
  assign timeout_hit  = (wait_inc >= 9'(MEM_TIMEOUT));

  // func7[5] only means sub for register-register adds; both forms use it for sra.
  always_comb begin
    alu_op_dec = ALU_ADD;
    case (func3)
      3'b000:  alu_op_dec = (state_reg == S_EXECR && func7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op_dec = ALU_SLL;
      3'b010:  alu_op_dec = ALU_SLT;
      3'b011:  alu_op_dec = ALU_SLTU;
      3'b100:  alu_op_dec = ALU_XOR;
      3'b101:  alu_op_dec = func7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op_dec = ALU_OR;
      default: alu_op_dec = ALU_AND;
    endcase
  end

  // slt/sltu leave Zero clear when "less", so the lt-style branches invert Zero.
  assign alu_br     = func3[2] ? (func3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
  assign br_taken   = (func3[2] ? ~Zero : Zero) ^ func3[0];
  assign br_illegal = (func3[2:1] == 2'b01);

  always_comb begin
    state_next = state_reg;
    wait_next  = '0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    InstrDone  = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    ImmSrc     = IMM_I;
    case (state_reg)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem.MemReady) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXECR;
          OP_I:              state_next = S_EXECI;
          OP_BR:             state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          default:           state_next = S_HALT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ImmSrc     = (op == OP_STORE) ? IMM_S : IMM_I;
        state_next = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem.MemReady) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        InstrDone  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem.MemReady) begin
          InstrDone  = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_op_dec;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_op_dec;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        InstrDone  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_br;
        ImmSrc     = IMM_B;
        PCWrite    = br_taken & ~br_illegal;
        InstrDone  = ~br_illegal;
        state_next = br_illegal ? S_HALT : S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCWrite    = 1'b1;
        state_next = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = S_JALR2;
      end
      // PC takes the jump target from ALUOut while OldPC+4 is computed for rd.
      S_JALR2: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCWrite    = 1'b1;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA    = 2'b11;
        ALUSrcB    = 2'b01;
        ImmSrc     = IMM_U;
        state_next = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        ImmSrc     = IMM_U;
        state_next = S_ALUWB;
      end
      default: state_next = S_HALT;
    endcase

    if (mem_req && !mem.MemReady) begin
      wait_next = wait_inc[7:0];
      if (timeout_hit) state_next = S_HALT;
    end

    // Nothing may be committed while reset is held, even mid-access.
    if (Rst) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      InstrDone = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg    <= S_FETCH;
      wait_cnt_reg <= '0;
      halted_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_next;
      halted_reg   <= halted_reg | (state_next == S_HALT);
    end
  end

  assign mem.MemReq   = mem_req;
  assign mem.MemWrite = mem_write;
  assign mem.AdrSrc   = adr_src;
  assign Halted       = halted_reg;

endmodule
